mv_stream_loader: RTL and testbench

//  Upstream feeder for the matrix-vector tensor unit. Accepts one D_WIDTH-bit AXI-Stream beat per cycle,

---
 rtl/mv_stream_loader_pkg.sv | 19 +
 rtl/mv_stream_loader_present_handshake.sv | 41 ++++
 rtl/mv_stream_loader.sv | 149 ++++++++++++++
 tb/tb_mv_stream_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mv_stream_loader_pkg.sv
// Shared definitions for the matrix-vector stream loader: FSM state codes and frame sizing helpers.
package mv_stream_loader_pkg;

   localparam logic [1:0] LOAD_MAT = 2'd0;
   localparam logic [1:0] LOAD_VEC = 2'd1;
   localparam logic [1:0] PRESENT  = 2'd2;
   localparam logic [1:0] DRAIN    = 2'd3;

   localparam int unsigned ERR_CNT_W = 16;

   function automatic int unsigned frame_len(input int unsigned m);
      return m * m + m;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned m);
      return $clog2(frame_len(m)) + 1;
   endfunction

endpackage

// File: rtl/mv_stream_loader_present_handshake.sv
// Two independent valid/done flags for presenting matrix and vector; all_done_o marks the cycle
// in which the last outstanding handshake completes.
module mv_present_handshake (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic mat_ready_i,
   input  logic vec_ready_i,
   output logic mat_valid_o,
   output logic vec_valid_o,
   output logic all_done_o
);

   logic mat_valid_q, mat_valid_d;
   logic vec_valid_q, vec_valid_d;

   always_comb begin
      mat_valid_d = mat_valid_q & ~mat_ready_i;
      vec_valid_d = vec_valid_q & ~vec_ready_i;
      if (start_i) begin
         mat_valid_d = 1'b1;
         vec_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mat_valid_q <= 1'b0;
         vec_valid_q <= 1'b0;
      end else begin
         mat_valid_q <= mat_valid_d;
         vec_valid_q <= vec_valid_d;
      end
   end

   // Done once nothing remains outstanding, whether the two handshakes coincide or not.
   assign all_done_o  = (mat_valid_q | vec_valid_q) & ~mat_valid_d & ~vec_valid_d;
   assign mat_valid_o = mat_valid_q;
   assign vec_valid_o = vec_valid_q;

endmodule

// File: rtl/mv_stream_loader.sv
// AXI-Stream frame loader feeding the matrix-vector tensor unit with a packed matrix and vector.
// Optional macro MV_LOADER_ERR_COUNT_EN adds a saturating 16-bit frame-error counter port.
module mv_stream_loader
   import mv_stream_loader_pkg::*;
#(
   parameter int unsigned D_WIDTH = 32,
   parameter int unsigned M_SIZE  = 2
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [D_WIDTH-1:0]              s_axis_tdata,
   input  logic                            s_axis_tvalid,
   input  logic                            s_axis_tlast,
   output logic                            s_axis_tready,
   output logic [D_WIDTH*M_SIZE*M_SIZE-1:0] o_matrix,
   output logic                            o_matrix_is_valid,
   input  logic                            i_ready_to_accept_matrix,
   output logic [D_WIDTH*M_SIZE-1:0]       o_vector,
   output logic                            o_vector_is_valid,
   input  logic                            i_ready_to_accept_vector,
`ifdef MV_LOADER_ERR_COUNT_EN
   output logic [ERR_CNT_W-1:0]            o_error_count,
`endif
   output logic                            o_frame_error
);

   localparam int unsigned NMAT = M_SIZE * M_SIZE;
   localparam int unsigned F    = frame_len(M_SIZE);
   localparam int unsigned CW   = cnt_width(M_SIZE);

   logic [1:0]                     state_q, state_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [D_WIDTH*NMAT-1:0]        mat_q, mat_d;
   logic [D_WIDTH*M_SIZE-1:0]      vec_q, vec_d;
   logic                           tready_q, tready_d;
   logic                           err_q, err_d;
   logic                           start;
   logic                           all_done;
   logic                           beat;

   assign beat = s_axis_tvalid & tready_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mat_d   = mat_q;
      vec_d   = vec_q;
      err_d   = 1'b0;
      start   = 1'b0;
      case (state_q)
         LOAD_MAT: begin
            if (beat) begin
               mat_d[int'(cnt_q) * int'(D_WIDTH) +: D_WIDTH] = s_axis_tdata;
               if (s_axis_tlast) begin
                  err_d = 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q == CW'(NMAT - 1)) state_d = LOAD_VEC;
               end
            end
         end
         LOAD_VEC: begin
            if (beat) begin
               vec_d[(int'(cnt_q) - int'(NMAT)) * int'(D_WIDTH) +: D_WIDTH] = s_axis_tdata;
               if (cnt_q == CW'(F - 1)) begin
                  cnt_d = '0;
                  if (s_axis_tlast) begin
                     state_d = PRESENT;
                     start   = 1'b1;
                  end else begin
                     state_d = DRAIN;
                     err_d   = 1'b1;
                  end
               end else if (s_axis_tlast) begin
                  state_d = LOAD_MAT;
                  cnt_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         PRESENT: begin
            if (all_done) state_d = LOAD_MAT;
         end
         DRAIN: begin
            if (beat && s_axis_tlast) begin
               state_d = LOAD_MAT;
               cnt_d   = '0;
            end
         end
         default: state_d = LOAD_MAT;
      endcase
      // Registered ready follows the next state so it is low exactly while presenting.
      tready_d = (state_d != PRESENT);
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q  <= LOAD_MAT;
         cnt_q    <= '0;
         mat_q    <= '0;
         vec_q    <= '0;
         tready_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mat_q    <= mat_d;
         vec_q    <= vec_d;
         tready_q <= tready_d;
         err_q    <= err_d;
      end
   end

   mv_present_handshake u_handshake (
      .clk_i       (aclk),
      .rst_i       (areset),
      .start_i     (start),
      .mat_ready_i (i_ready_to_accept_matrix),
      .vec_ready_i (i_ready_to_accept_vector),
      .mat_valid_o (o_matrix_is_valid),
      .vec_valid_o (o_vector_is_valid),
      .all_done_o  (all_done)
   );

`ifdef MV_LOADER_ERR_COUNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign o_error_count = err_cnt_q;
`endif

   assign s_axis_tready = tready_q;
   assign o_matrix      = mat_q;
   assign o_vector      = vec_q;
   assign o_frame_error = err_q;

endmodule

// File: tb/tb_mv_stream_loader.sv
// Testbench for mv_stream_loader: directed scenarios plus randomized frames against a frame-level model.
module tb_mv_stream_loader;

   localparam int unsigned DW = 32;
   localparam int unsigned MS = 2;
   localparam int unsigned NM = MS * MS;
   localparam int unsigned F  = NM + MS;

   logic              aclk = 1'b0;
   logic              areset;
   logic [DW-1:0]     s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tlast;
   logic              s_axis_tready;
   logic [DW*NM-1:0]  o_matrix;
   logic              o_matrix_is_valid;
   logic              i_ready_to_accept_matrix;
   logic [DW*MS-1:0]  o_vector;
   logic              o_vector_is_valid;
   logic              i_ready_to_accept_vector;
   logic              o_frame_error;
`ifdef MV_LOADER_ERR_COUNT_EN
   logic [15:0]       o_error_count;
`endif

   always #5 aclk = ~aclk;

   mv_stream_loader #(.D_WIDTH(DW), .M_SIZE(MS)) dut (
      .aclk                     (aclk),
      .areset                   (areset),
      .s_axis_tdata             (s_axis_tdata),
      .s_axis_tvalid            (s_axis_tvalid),
      .s_axis_tlast             (s_axis_tlast),
      .s_axis_tready            (s_axis_tready),
      .o_matrix                 (o_matrix),
      .o_matrix_is_valid        (o_matrix_is_valid),
      .i_ready_to_accept_matrix (i_ready_to_accept_matrix),
      .o_vector                 (o_vector),
      .o_vector_is_valid        (o_vector_is_valid),
      .i_ready_to_accept_vector (i_ready_to_accept_vector),
`ifdef MV_LOADER_ERR_COUNT_EN
      .o_error_count            (o_error_count),
`endif
      .o_frame_error            (o_frame_error)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Frame-level reference model
   logic [DW-1:0]    q[$];
   bit               drain;
   logic             exp_mv, exp_vv, exp_rdy, exp_err;
   logic [DW*NM-1:0] exp_mat;
   logic [DW*MS-1:0] exp_vec;
   int unsigned      exp_errcnt;
   bit               acc;
   bit               rand_rdy;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic mv_n, vv_n, err_n;
      if (rand_rdy) begin
         i_ready_to_accept_matrix = 1'($urandom_range(0, 1));
         i_ready_to_accept_vector = 1'($urandom_range(0, 1));
      end
      @(negedge aclk);
      chk("tready", s_axis_tready, exp_rdy);
      chk("frame_error", o_frame_error, exp_err);
      chk("matrix_valid", o_matrix_is_valid, exp_mv);
      chk("vector_valid", o_vector_is_valid, exp_vv);
      if (exp_mv || exp_vv) begin
         chk("matrix_data", o_matrix, exp_mat);
         chk("vector_data", o_vector, exp_vec);
      end
`ifdef MV_LOADER_ERR_COUNT_EN
      chk("error_count", o_error_count, exp_errcnt);
`endif
      acc   = s_axis_tvalid && exp_rdy;
      err_n = 1'b0;
      mv_n  = exp_mv && !i_ready_to_accept_matrix;
      vv_n  = exp_vv && !i_ready_to_accept_vector;
      if (!(exp_mv || exp_vv) && acc) begin
         if (drain) begin
            if (s_axis_tlast) drain = 0;
         end else begin
            q.push_back(s_axis_tdata);
            if (q.size() == F) begin
               if (s_axis_tlast) begin
                  for (int k = 0; k < F; k++) begin
                     if (k < NM) exp_mat[k*DW +: DW] = q[k];
                     else        exp_vec[(k-NM)*DW +: DW] = q[k];
                  end
                  mv_n = 1'b1;
                  vv_n = 1'b1;
               end else begin
                  err_n = 1'b1;
                  drain = 1;
               end
               q.delete();
            end else if (s_axis_tlast) begin
               err_n = 1'b1;
               q.delete();
            end
         end
      end
      exp_mv  = mv_n;
      exp_vv  = vv_n;
      exp_err = err_n;
      exp_rdy = !(mv_n || vv_n);
      if (err_n && exp_errcnt < 65535) exp_errcnt++;
      @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic last);
      bit done = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (acc) done = 1;
      end
      chk("send_timeout", {127'b0, done}, 128'd1);
   endtask

   task automatic idle(input int unsigned n);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      areset        = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = '0;
      q.delete();
      drain      = 0;
      exp_errcnt = 0;
      @(negedge aclk);
      chk("rst_tready", s_axis_tready, 1'b0);
      chk("rst_mvalid", o_matrix_is_valid, 1'b0);
      chk("rst_vvalid", o_vector_is_valid, 1'b0);
      chk("rst_error", o_frame_error, 1'b0);
      chk("rst_matrix", o_matrix, '0);
      chk("rst_vector", o_vector, '0);
`ifdef MV_LOADER_ERR_COUNT_EN
      chk("rst_err_count", o_error_count, '0);
`endif
      @(posedge aclk);
      #1;
      areset  = 1'b0;
      exp_rdy = 1'b0;
      exp_mv  = 1'b0;
      exp_vv  = 1'b0;
      exp_err = 1'b0;
   endtask

   task automatic send_seq(input int unsigned first, input int unsigned n, input bit last_on_end);
      for (int unsigned i = 0; i < n; i++)
         send(DW'(first + i), (i == n - 1) && last_on_end);
   endtask

   initial begin
      rand_rdy                 = 0;
      exp_mat                  = '0;
      exp_vec                  = '0;
      i_ready_to_accept_matrix = 1'b1;
      i_ready_to_accept_vector = 1'b1;
      do_reset();

      // 1: back-to-back clean frame with readies already high
      send_seq(1, F, 1);
      #3;
      chk("t1_matrix", o_matrix, {32'd4, 32'd3, 32'd2, 32'd1});
      chk("t1_vector", o_vector, {32'd6, 32'd5});
      chk("t1_mvalid", o_matrix_is_valid, 1'b1);
      chk("t1_vvalid", o_vector_is_valid, 1'b1);
      idle(3);

      // 2: matrix taken one cycle after valid, vector five cycles after
      i_ready_to_accept_matrix = 1'b0;
      i_ready_to_accept_vector = 1'b0;
      send_seq(1, F, 1);
      idle(1);
      i_ready_to_accept_matrix = 1'b1;
      idle(1);
      i_ready_to_accept_matrix = 1'b0;
      idle(3);
      i_ready_to_accept_vector = 1'b1;
      idle(1);
      i_ready_to_accept_matrix = 1'b1;
      idle(2);

      // 3: early tlast, then a clean frame
      send_seq(1, 3, 1);
      idle(2);
      send_seq(7, F, 1);
      idle(1);
      chk("t3_matrix", o_matrix, {32'd10, 32'd9, 32'd8, 32'd7});
      chk("t3_vector", o_vector, {32'd12, 32'd11});
      idle(2);

      // 4: missing tlast, drain two beats, then a clean frame
      send_seq(1, F, 0);
      send_seq(20, 2, 1);
      send_seq(31, F, 1);
      idle(3);

      // 5: reset mid-frame, then a clean frame
      send_seq(1, 4, 0);
      do_reset();
      send_seq(1, F, 1);
      idle(1);
      chk("t5_matrix", o_matrix, {32'd4, 32'd3, 32'd2, 32'd1});
      chk("t5_vector", o_vector, {32'd6, 32'd5});
      idle(2);

`ifdef MV_LOADER_ERR_COUNT_EN
      // 6: three bad frames counted, cleared by reset
      do_reset();
      send_seq(1, 2, 1);
      send_seq(1, 1, 1);
      send_seq(1, F, 0);
      send_seq(1, 1, 1);
      idle(2);
      chk("t6_err_count", o_error_count, 16'd3);
      do_reset();
`endif

      // Randomized frames: good, short, and overlong with drain
      rand_rdy = 1;
      for (int f = 0; f < 40; f++) begin
         int unsigned kind = $urandom_range(0, 3);
         int unsigned len;
         len = (kind == 2) ? $urandom_range(1, F - 1) : F;
         for (int unsigned b = 0; b < len; b++) begin
            idle($urandom_range(0, 2));
            send($urandom, (kind != 3) && (b == len - 1));
         end
         if (kind == 3) begin
            int unsigned extra = $urandom_range(0, 2);
            for (int unsigned b = 0; b <= extra; b++) begin
               idle($urandom_range(0, 1));
               send($urandom, b == extra);
            end
         end
      end
      rand_rdy                 = 0;
      i_ready_to_accept_matrix = 1'b1;
      i_ready_to_accept_vector = 1'b1;
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
